// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Arbitrates two write requesters (A = ALU, B = load unit) onto the single
//   write port of the register file. Requests are accepted combinationally and
//   issued one cycle later from a one-entry output stage. Ties are broken by
//   a priority pointer that alternates after every contested grant. Read
//   addresses of the current instruction are compared against the write in
//   flight to flag read-after-write hazards.
//
//   Optional feature: define REGFILE_ARB_STATS_EN to add conflict_cnt, a
//   saturating count of cycles in which both requesters were valid.
//
// Parameters
//   INIT_PRIO   requester favoured first after reset (0 = A, 1 = B)
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_valid/a_addr/a_data      requester A write request
//   b_valid/b_addr/b_data      requester B write request
//   a_ready/b_ready            request accepted this cycle (combinational)
//   rf_write/rf_addr_in/rf_data_in  register-file write port (registered)
//   rd_addr_a/rd_addr_b        current read addresses
//   hazard_a/hazard_b          read address matches the in-flight write
//   conflict_cnt               (REGFILE_ARB_STATS_EN only) contested cycles
module regfile_write_arbiter #(
    parameter logic INIT_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        a_ready,
    output logic        b_ready,
    output logic        rf_write,
    output logic [4:0]  rf_addr_in,
    output logic [31:0] rf_data_in,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    output logic        hazard_a,
    output logic        hazard_b
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [15:0] conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_A = 2'd1,
        ISSUE_B = 2'd2
    } state_t;

    state_t      state_p1, state_d;
    logic        prio_p1, prio_d;     // 0 = A favoured on a tie
    logic [4:0]  wr_addr_p1;
    logic [31:0] wr_data_p1;
    logic        contested;
    logic        grant_a, grant_b;

    // Stage 0: arbitration and next-state selection
    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        prio_d    = prio_p1;
        state_d   = IDLE;
        contested = a_valid & b_valid;

        // No grants while reset is held, so nothing is accepted then.
        if (rst_n) begin
            if (contested) begin
                grant_a = ~prio_p1;
                grant_b = prio_p1;
                // Point at the loser so it wins the next tie.
                prio_d  = ~prio_p1;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end

        // A register-0 write is accepted but never issued.
        if (grant_a && (a_addr != 5'd0)) begin
            state_d = ISSUE_A;
        end else if (grant_b && (b_addr != 5'd0)) begin
            state_d = ISSUE_B;
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Stage 1: one-entry output stage, drained every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1   <= IDLE;
            prio_p1    <= INIT_PRIO;
            wr_addr_p1 <= 5'd0;
            wr_data_p1 <= 32'd0;
        end else begin
            state_p1 <= state_d;
            prio_p1  <= prio_d;
            // Address/data only move on an issued write; otherwise they hold.
            if (state_d == ISSUE_A) begin
                wr_addr_p1 <= a_addr;
                wr_data_p1 <= a_data;
            end else if (state_d == ISSUE_B) begin
                wr_addr_p1 <= b_addr;
                wr_data_p1 <= b_data;
            end
        end
    end

    assign rf_write   = (state_p1 != IDLE);
    assign rf_addr_in = wr_addr_p1;
    assign rf_data_in = wr_data_p1;

    // Register 0 reads are never hazards; rf_write is already 0 in reset, the
    // rst_n term keeps the flags quiet for the whole reset window regardless.
    assign hazard_a = rst_n & rf_write & (rd_addr_a == wr_addr_p1) & (rd_addr_a != 5'd0);
    assign hazard_b = rst_n & rf_write & (rd_addr_b == wr_addr_p1) & (rd_addr_b != 5'd0);

`ifdef REGFILE_ARB_STATS_EN
    // Saturating contested-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= 16'd0;
        end else if (contested && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a
// randomized run compared against a behavioural model of the arbiter.
module tb_regfile_write_arbiter;

    localparam logic TB_PRIO = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        rf_write;
    logic [4:0]  rf_addr_in;
    logic [31:0] rf_data_in;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic        hazard_a, hazard_b;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state: who wins the next tie and what the write port shows.
    logic        m_prio;
    logic        m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_cnt;
    logic        e_ar, e_br, e_ha, e_hb;

    regfile_write_arbiter #(.INIT_PRIO(TB_PRIO)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data),
        .a_ready(a_ready), .b_ready(b_ready),
        .rf_write(rf_write), .rf_addr_in(rf_addr_in), .rf_data_in(rf_data_in),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b)
`ifdef REGFILE_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic model_reset();
        m_prio = TB_PRIO; m_wr = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_cnt = 0;
    endtask

    // Expected combinational outputs for the current inputs.
    task automatic model_eval();
        e_ar = 1'b0; e_br = 1'b0;
        if (rst_n === 1'b1) begin
            if (a_valid && b_valid) begin
                if (m_prio == 1'b0) e_ar = 1'b1; else e_br = 1'b1;
            end else begin
                e_ar = a_valid;
                e_br = b_valid;
            end
        end
        e_ha = (rst_n === 1'b1) && m_wr && (rd_addr_a == m_addr) && (rd_addr_a != 0);
        e_hb = (rst_n === 1'b1) && m_wr && (rd_addr_b == m_addr) && (rd_addr_b != 0);
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst_n !== 1'b1) begin
            model_reset();
        end else begin
            if (a_valid && b_valid) begin
                m_prio = ~m_prio;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
            if (e_ar && a_addr != 0) begin
                m_wr = 1'b1; m_addr = a_addr; m_data = a_data;
            end else if (e_br && b_addr != 0) begin
                m_wr = 1'b1; m_addr = b_addr; m_data = b_data;
            end else begin
                m_wr = 1'b0;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        rd_addr_a = 0; rd_addr_b = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        rd_addr_a = 0; rd_addr_b = 0;
        repeat (2) @(posedge clk);
        #4;
        n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_bad++;
            $display("FAIL reset_ready: a_ready=%b b_ready=%b required 0 0", a_ready, b_ready); end
        n_cmp++; if (rf_write !== 1'b0) begin n_bad++;
            $display("FAIL reset_rf_write: got %b required 0", rf_write); end
        n_cmp++; if (rf_addr_in !== 5'd0 || rf_data_in !== 32'd0) begin n_bad++;
            $display("FAIL reset_rf_addr_data: got %0d %h required 0 0", rf_addr_in, rf_data_in); end
        n_cmp++; if (hazard_a !== 1'b0 || hazard_b !== 1'b0) begin n_bad++;
            $display("FAIL reset_hazard: got %b %b required 0 0", hazard_a, hazard_b); end
`ifdef REGFILE_ARB_STATS_EN
        n_cmp++; if (conflict_cnt !== 16'd0) begin n_bad++;
            $display("FAIL reset_conflict_cnt: got %0d required 0", conflict_cnt); end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_single_a();
        drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        #4;
        n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_bad++;
            $display("FAIL single_a_ready: a_ready=%b b_ready=%b required 1 0", a_ready, b_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #4;
        n_cmp++; if (rf_write !== 1'b1 || rf_addr_in !== 5'd5 || rf_data_in !== 32'hDEADBEEF) begin n_bad++;
            $display("FAIL single_a_write: got %b %0d %h required 1 5 deadbeef", rf_write, rf_addr_in, rf_data_in); end
        tick();
        #4;
        n_cmp++; if (rf_write !== 1'b0) begin n_bad++;
            $display("FAIL single_a_drain: rf_write=%b required 0", rf_write); end
        tick();
    endtask

    task automatic test_contested();
        logic exp_a;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'(10 + i), 32'hA000 + i, 1, 5'(20 + i), 32'hB000 + i);
            exp_a = ((i % 2) == 0) ? ~TB_PRIO : TB_PRIO;
            #4;
            n_cmp++; if (a_ready !== exp_a || b_ready !== ~exp_a) begin n_bad++;
                $display("FAIL contested_grant_%0d: a_ready=%b b_ready=%b required %b %b",
                         i, a_ready, b_ready, exp_a, ~exp_a); end
            tick();
            n_cmp++; if (rf_write !== 1'b1 || rf_addr_in !== (exp_a ? 5'(10 + i) : 5'(20 + i))) begin n_bad++;
                $display("FAIL contested_issue_%0d: got %b %0d required 1 %0d",
                         i, rf_write, rf_addr_in, exp_a ? 10 + i : 20 + i); end
        end
        drive(0, 0, 0, 0, 0, 0);
`ifdef REGFILE_ARB_STATS_EN
        #4;
        n_cmp++; if (conflict_cnt !== 16'd4) begin n_bad++;
            $display("FAIL contested_conflict_cnt: got %0d required 4", conflict_cnt); end
`endif
        tick();
    endtask

    task automatic test_addr_zero();
        logic [4:0]  prev_addr;
        logic [31:0] prev_data;
        drive(1, 5'd12, 32'hCAFE0012, 0, 0, 0);
        tick();
        prev_addr = 5'd12; prev_data = 32'hCAFE0012;
        drive(0, 0, 0, 1, 5'd0, 32'h1);
        #4;
        n_cmp++; if (b_ready !== 1'b1) begin n_bad++;
            $display("FAIL addr0_ready: b_ready=%b required 1", b_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #4;
        n_cmp++; if (rf_write !== 1'b0) begin n_bad++;
            $display("FAIL addr0_no_write: rf_write=%b required 0", rf_write); end
        n_cmp++; if (rf_addr_in !== prev_addr || rf_data_in !== prev_data) begin n_bad++;
            $display("FAIL addr0_hold: got %0d %h required %0d %h", rf_addr_in, rf_data_in, prev_addr, prev_data); end
        tick();
    endtask

    task automatic test_hazard();
        drive(1, 5'd7, 32'h77, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rd_addr_a = 5'd7; rd_addr_b = 5'd0;
        #4;
        n_cmp++; if (hazard_a !== 1'b1 || hazard_b !== 1'b0) begin n_bad++;
            $display("FAIL hazard_a_only: got %b %b required 1 0", hazard_a, hazard_b); end
        rd_addr_a = 5'd6; rd_addr_b = 5'd7;
        #1;
        n_cmp++; if (hazard_a !== 1'b0 || hazard_b !== 1'b1) begin n_bad++;
            $display("FAIL hazard_b_only: got %b %b required 0 1", hazard_a, hazard_b); end
        tick();
        #4;
        n_cmp++; if (hazard_b !== 1'b0) begin n_bad++;
            $display("FAIL hazard_idle: hazard_b=%b required 0", hazard_b); end
        rd_addr_a = 0; rd_addr_b = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 5'd9, 32'h99, 0, 0, 0);
        #2;
        n_cmp++; if (a_ready !== 1'b1) begin n_bad++;
            $display("FAIL rstmid_pre_ready: a_ready=%b required 1", a_ready); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++;
            $display("FAIL rstmid_ready_in_reset: a_ready=%b required 0", a_ready); end
        @(posedge clk); #1;
        n_cmp++; if (rf_write !== 1'b0) begin n_bad++;
            $display("FAIL rstmid_no_write: rf_write=%b required 0", rf_write); end
        rst_n = 1'b1;
        model_reset();
        drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
        #4;
        n_cmp++; if (a_ready !== ~TB_PRIO || b_ready !== TB_PRIO) begin n_bad++;
            $display("FAIL rstmid_first_grant: a_ready=%b b_ready=%b required %b %b",
                     a_ready, b_ready, ~TB_PRIO, TB_PRIO); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (rf_write !== 1'b1 || rf_addr_in !== (TB_PRIO ? 5'd4 : 5'd3)) begin n_bad++;
            $display("FAIL rstmid_first_issue: got %b %0d required 1 %0d",
                     rf_write, rf_addr_in, TB_PRIO ? 4 : 3); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
                  $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
            rd_addr_a = $urandom_range(0, 1) ? m_addr : 5'($urandom_range(0, 31));
            rd_addr_b = $urandom_range(0, 1) ? m_addr : 5'($urandom_range(0, 31));
            #4;
            model_eval();
            n_cmp++; if (a_ready !== e_ar || b_ready !== e_br) begin n_bad++;
                $display("FAIL rand_ready[%0d]: got %b %b required %b %b", i, a_ready, b_ready, e_ar, e_br); end
            n_cmp++; if (rf_write !== m_wr || rf_addr_in !== m_addr || rf_data_in !== m_data) begin n_bad++;
                $display("FAIL rand_port[%0d]: got %b %0d %h required %b %0d %h",
                         i, rf_write, rf_addr_in, rf_data_in, m_wr, m_addr, m_data); end
            n_cmp++; if (hazard_a !== e_ha || hazard_b !== e_hb) begin n_bad++;
                $display("FAIL rand_hazard[%0d]: got %b %b required %b %b", i, hazard_a, hazard_b, e_ha, e_hb); end
`ifdef REGFILE_ARB_STATS_EN
            n_cmp++; if (conflict_cnt !== 16'(m_cnt)) begin n_bad++;
                $display("FAIL rand_conflict_cnt[%0d]: got %0d required %0d", i, conflict_cnt, m_cnt); end
`endif
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        rd_addr_a = 0; rd_addr_b = 0;
    endtask

`ifdef REGFILE_ARB_STATS_EN
    task automatic test_saturate();
        apply_reset();
        drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
        repeat (70000) @(posedge clk);
        #1;
        n_cmp++; if (conflict_cnt !== 16'hFFFF) begin n_bad++;
            $display("FAIL saturate_conflict_cnt: got %h required ffff", conflict_cnt); end
        drive(0, 0, 0, 0, 0, 0);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        rd_addr_a = 0; rd_addr_b = 0;
        model_reset();
        #1;
        test_reset();
        test_single_a();
        test_contested();
        test_addr_zero();
        test_hazard();
        test_reset_mid();
        test_random();
`ifdef REGFILE_ARB_STATS_EN
        test_saturate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
